// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: opcodes, condition-code reset value, decode FSM
// states and a helper that derives N/Z/P flags from a written-back value.
package lc3_pkg;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_RES  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    localparam logic [2:0] NZP_RESET = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEM_WAIT,
        S_LATCH,
        S_ISSUE,
        S_EXEC_WAIT,
        S_NEXT
    } state_t;

    function automatic logic [2:0] nzp_of(input logic [15:0] d);
        return {d[15], d == 16'h0000, !d[15] && (d != 16'h0000)};
    endfunction

endpackage

// File: rtl/lc3_decode_if.sv
// Bundle between the decode stage and its neighbours (BRAM, fetch, execute,
// writeback). slave = decode stage, master = the surrounding pipeline.
interface lc3_decode_if;

    logic        start_in;
    logic [15:0] mem_dout;
    logic        exec_done_in;
    logic        wb_en_in;
    logic [15:0] wb_data_in;

    logic [15:0] ir_out;
    logic [3:0]  opCode_out;
    logic [2:0]  dr_out;
    logic [2:0]  sr1_out;
    logic [2:0]  sr2_out;
    logic        imm_mode_out;
    logic [8:0]  offset_out;
    logic [15:0] sext_out;
    logic [2:0]  br_nzp_out;
    logic [2:0]  result_nzp_out;
    logic        exec_start_out;
    logic        fetch_start_out;
    logic        busy_out;
    logic        illegal_out;

    modport slave (
        input  start_in, mem_dout, exec_done_in, wb_en_in, wb_data_in,
        output ir_out, opCode_out, dr_out, sr1_out, sr2_out,
        output imm_mode_out, offset_out, sext_out, br_nzp_out,
        output result_nzp_out, exec_start_out, fetch_start_out,
        output busy_out, illegal_out
    );

    modport master (
        output start_in, mem_dout, exec_done_in, wb_en_in, wb_data_in,
        input  ir_out, opCode_out, dr_out, sr1_out, sr2_out,
        input  imm_mode_out, offset_out, sext_out, br_nzp_out,
        input  result_nzp_out, exec_start_out, fetch_start_out,
        input  busy_out, illegal_out
    );

endinterface

// File: rtl/lc3_sext.sv
// Combinational immediate/offset extender.
// Ports: ir (instruction), op (opcode) -> sext (16-bit extended value).
module lc3_sext
    import lc3_pkg::*;
(
    input  logic [15:0] ir,
    input  logic [3:0]  op,
    output logic [15:0] sext
);

    logic is_imm5;
    logic is_off6;
    logic is_off11;
    logic is_off9;
    logic is_trap;

    always_comb begin
        is_imm5  = ((op == OP_ADD) || (op == OP_AND)) && ir[5];
        is_off6  = (op == OP_LDR) || (op == OP_STR);
        is_off11 = (op == OP_JSR);
        is_off9  = (op == OP_BR)  || (op == OP_LD)  || (op == OP_ST) ||
                   (op == OP_LDI) || (op == OP_STI) || (op == OP_LEA);
        is_trap  = (op == OP_TRAP);
    end

    always_comb begin
        sext = 16'h0000;
        unique case (1'b1)
            is_imm5:  sext = {{11{ir[4]}}, ir[4:0]};
            is_off6:  sext = {{10{ir[5]}}, ir[5:0]};
            is_off11: sext = {{5{ir[10]}}, ir[10:0]};
            is_off9:  sext = {{7{ir[8]}}, ir[8:0]};
            is_trap:  sext = {8'h00, ir[7:0]};
            default:  sext = 16'h0000;
        endcase
    end

endmodule

// File: rtl/lc3_decode.sv
// LC-3 decode/sequencing stage: waits on BRAM, latches IR, issues to execute,
// then hands back to fetch. Owns the N/Z/P condition-code register.
// Ports: clk, rst (async, active high), bus (lc3_decode_if.slave).
module lc3_decode
    import lc3_pkg::*;
#(
    parameter int         MEM_LAT    = 1,
    parameter logic [3:0] ILLEGAL_OP = 4'b1101
) (
    input  logic          clk,
    input  logic          rst,
    lc3_decode_if.slave   bus
);

    localparam logic [1:0] WAIT_LAST = 2'(MEM_LAT - 1);

    state_t      state_q, state_d;
    logic [1:0]  wait_q, wait_d;
    logic [15:0] ir_q, ir_d;
    logic [2:0]  nzp_q, nzp_d;
    logic        illegal_q, illegal_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wait_q    <= 2'd0;
            ir_q      <= 16'h0000;
            nzp_q     <= NZP_RESET;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            ir_q      <= ir_d;
            nzp_q     <= nzp_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: begin
                wait_d = 2'd0;
                if (bus.start_in) state_d = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                if (wait_q == WAIT_LAST) state_d = S_LATCH;
                else                     wait_d  = wait_q + 2'd1;
            end
            S_LATCH: begin
                ir_d = bus.mem_dout;
                // Reserved opcode skips execute but still returns to fetch.
                if (bus.mem_dout[15:12] == ILLEGAL_OP) begin
                    illegal_d = 1'b1;
                    state_d   = S_NEXT;
                end else begin
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE:     state_d = S_EXEC_WAIT;
            S_EXEC_WAIT: if (bus.exec_done_in) state_d = S_NEXT;
            S_NEXT:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Writeback updates flags in every state, independent of sequencing.
    always_comb begin
        nzp_d = nzp_q;
        if (bus.wb_en_in) nzp_d = nzp_of(bus.wb_data_in);
    end

    logic [15:0] sext;

    lc3_sext u_sext (
        .ir   (ir_q),
        .op   (ir_q[15:12]),
        .sext (sext)
    );

    always_comb begin
        bus.ir_out          = ir_q;
        bus.opCode_out      = ir_q[15:12];
        bus.dr_out          = ir_q[11:9];
        bus.sr1_out         = ir_q[8:6];
        bus.sr2_out         = ir_q[2:0];
        bus.imm_mode_out    = ir_q[5];
        bus.offset_out      = ir_q[8:0];
        bus.br_nzp_out      = ir_q[11:9];
        bus.sext_out        = sext;
        bus.result_nzp_out  = nzp_q;
        bus.exec_start_out  = (state_q == S_ISSUE);
        bus.fetch_start_out = (state_q == S_NEXT);
        bus.busy_out        = (state_q != S_IDLE);
        bus.illegal_out     = illegal_q;
    end

endmodule

// File: doc/lc3_decode.md
Name: lc3_decode

Overview:
- Decode/sequencing stage directly downstream of `fetch`.
- Fetch drives `addr_out`/`pc` into instruction BRAM. This block reads the returned word, latches it into IR, splits the fields and issues to execute.
- After execute completes it returns `opCode`/`offset9`/`br_nzp`/`result_nzp` to fetch and pulses `fetch_start` for the next PC.
- Owns the LC-3 N/Z/P condition-code register.

Parameters:
- MEM_LAT, 1, BRAM read latency in cycles (1..3); number of MEM_WAIT cycles.
- ILLEGAL_OP, 4'b1101, reserved opcode flagged as illegal.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_in  in  1  one-cycle pulse: fetch has put a new address on the BRAM.
- mem_dout  in  16  BRAM read data.
- exec_done_in  in  1  one-cycle pulse: execute finished the issued instruction.
- wb_en_in  in  1  register writeback strobe; updates condition codes.
- wb_data_in  in  16  writeback value.
- ir_out  out  16  latched instruction register.
- opCode_out  out  4  IR[15:12]; feeds fetch `opCode_in`.
- dr_out  out  3  IR[11:9].
- sr1_out  out  3  IR[8:6].
- sr2_out  out  3  IR[2:0].
- imm_mode_out  out  1  IR[5].
- offset_out  out  9  IR[8:0]; feeds fetch `offset_in`.
- sext_out  out  16  sign-extended immediate/offset, selected by opcode.
- br_nzp_out  out  3  IR[11:9]; feeds fetch `br_nzp`.
- result_nzp_out  out  3  condition-code register; feeds fetch `result_nzp`.
- exec_start_out  out  1  one-cycle issue pulse to execute.
- fetch_start_out  out  1  one-cycle pulse to fetch `fetch_start`.
- busy_out  out  1  high in any state except IDLE.
- illegal_out  out  1  sticky; set when ILLEGAL_OP is decoded.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; IR=16'h0000, so all field outputs are 0 and sext_out=0.
  - result_nzp_out=3'b010 (Z).
  - exec_start_out, fetch_start_out, busy_out, illegal_out all 0.
- Reset mid-operation aborts immediately. Any pending exec_done_in is ignored after release.
- FSM states: IDLE, MEM_WAIT, LATCH, ISSUE, EXEC_WAIT, NEXT.
  - IDLE: start_in=1 -> MEM_WAIT. Otherwise stay.
  - MEM_WAIT: a wait counter counts MEM_LAT cycles, then -> LATCH.
  - LATCH: IR<=mem_dout at the clock edge leaving LATCH.
    - opcode==ILLEGAL_OP -> illegal_out<=1, -> NEXT (no issue).
    - otherwise -> ISSUE.
  - ISSUE: exec_start_out=1 for exactly this cycle -> EXEC_WAIT.
  - EXEC_WAIT: exec_done_in=1 -> NEXT. Otherwise stay; there is no timeout.
  - NEXT: fetch_start_out=1 for exactly this cycle -> IDLE.
- Timing (MEM_LAT=1, start_in sampled at edge 0):
  - MEM_WAIT cycle 1; LATCH cycle 2.
  - IR and fields valid from cycle 3.
  - exec_start_out high in cycle 3.
- start_in outside IDLE is ignored. exec_done_in outside EXEC_WAIT is ignored.
- Field outputs are driven combinationally from IR and are stable from LATCH exit until the next LATCH.
- sext_out selection by opcode:
  - ADD/AND with imm_mode=1: SEXT(IR[4:0]).
  - LDR/STR: SEXT(IR[5:0]).
  - JSR: SEXT(IR[10:0]).
  - BR/LD/ST/LDI/STI/LEA: SEXT(IR[8:0]).
  - TRAP: ZEXT(IR[7:0]).
  - all others: 0.
- Condition codes, on any cycle with wb_en_in=1 in any state:
  - nzp <= {wb_data_in[15], wb_data_in==0, !wb_data_in[15] && wb_data_in!=0}.
  - Exactly one bit is ever set.
- If wb_en_in coincides with the LATCH edge, both updates occur. The nzp value is visible to fetch at NEXT.
- illegal_out clears only on rst.

Decomposition:
- Shared package `lc3_pkg`:
  - opcode localparams (OP_BR=4'b0000, OP_ADD=4'b0001, …, OP_TRAP=4'b1111);
  - NZP reset constant 3'b010;
  - FSM state encoding.
- Sub-module `lc3_sext`: purely combinational; IR + opcode -> 16-bit extended immediate. Reusable by execute.

Test Plan:
- Reset check: hold rst 5 cycles, release -> all outputs 0 except result_nzp_out=3'b010; busy_out=0.
- ADD R1,R1,#1:
  - start_in with mem_dout=16'h1261 -> opCode=4'h1, dr=1, sr1=1, imm_mode=1, sext_out=16'h0001.
  - exec_start_out pulses in cycle 3.
  - exec_done_in -> fetch_start_out pulses one cycle later.
- BRnp +5: mem_dout=16'h0A05 -> opCode=0, br_nzp_out=3'b101, offset_out=9'h005, sext_out=16'h0005.
- NZP update:
  - wb_en_in with 16'h8000 -> 3'b100;
  - then 16'h0000 -> 3'b010;
  - then 16'h7FFF -> 3'b001.
- Illegal opcode: mem_dout=16'hD000 -> illegal_out=1, exec_start_out never asserted, fetch_start_out pulses, back to IDLE.
- Abort: assert rst during EXEC_WAIT, then pulse exec_done_in after release -> no fetch_start_out; state IDLE; IR=0.
